// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: frequency word, note numbers,
// event kinds, FSM states and the captured-event record.
package mypackage;

  localparam int FREQUENCY_BITS            = 32;
  localparam int FREQUENCY_FRACTIONAL_BITS = 8;
  typedef logic [FREQUENCY_BITS-1:0] frequency;

  localparam int NOTE_BITS = 7;
  typedef logic [NOTE_BITS-1:0] note_t;

  localparam logic NOTE_ON  = 1'b1;
  localparam logic NOTE_OFF = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    COMMIT
  } va_state_e;

  typedef struct packed {
    logic     on;
    note_t    note;
    frequency freq;
  } va_event_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the key front end and the voice allocator.
interface voice_allocator_if
  import mypackage::*;
();
  logic     ev_valid;
  logic     ev_ready;
  logic     ev_on;
  note_t    ev_note;
  frequency ev_freq;

  modport master (output ev_valid, ev_on, ev_note, ev_freq, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, ev_freq, output ev_ready);
endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters plus the running "oldest voice" register
// that the allocator's scan updates one voice per cycle.
module voice_age_tracker
  import mypackage::*;
#(
  parameter int NVOICES  = 4,
  parameter int AGE_BITS = 8,
  parameter int IDX_W    = $clog2(NVOICES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NVOICES-1:0] gate,
  input  logic               touch,
  input  logic [IDX_W-1:0]   touch_idx,
  input  logic               scan_load,
  input  logic [IDX_W-1:0]   scan_idx,
  output logic               scan_older,
  output logic [IDX_W-1:0]   oldest_idx
);
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  logic [AGE_BITS-1:0] age [NVOICES];

  // A touch restarts the target's age and ages every other sounding voice.
  for (genvar i = 0; i < NVOICES; i++) begin : g_age
    always_ff @(posedge clock) begin
      if (reset) begin
        age[i] <= '0;
      end else if (touch) begin
        if (touch_idx == IDX_W'(i))
          age[i] <= '0;
        else if (gate[i] && age[i] != AGE_MAX)
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Strictly older wins, so ties stay with the lower index seen first.
  assign scan_older = age[scan_idx] > age[oldest_idx];

  always_ff @(posedge clock) begin
    if (reset)          oldest_idx <= '0;
    else if (scan_load) oldest_idx <= scan_idx;
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the voice pool one voice per cycle and
// commits note-on/off events. Define VOICE_ALLOCATOR_STEAL_EN to steal the
// oldest voice when all are sounding; otherwise such note-ons are dropped.
module voice_allocator
  import mypackage::*;
#(
  parameter int NVOICES  = 4,
  parameter int AGE_BITS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  voice_allocator_if.slave         ev,
  output frequency [NVOICES-1:0]   voice_freq,
  output logic     [NVOICES-1:0]   voice_gate,
  output note_t    [NVOICES-1:0]   voice_note,
  output logic     [NVOICES-1:0]   voice_trig,
  output logic                     dropped
);
  localparam int               IDX_W    = $clog2(NVOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVOICES - 1);

  va_state_e        state;
  va_event_t        cap;
  logic [IDX_W-1:0] scan_idx, match_idx, free_idx, oldest_idx, on_tgt;
  logic             match_found, free_found, on_hit;
  logic             scan_older, scan_load, touch;

  assign ev.ev_ready = (state == IDLE);

  // Note-on target: retrigger a matching voice, else the first free one,
  // else (when stealing) the oldest.
  always_comb begin
    on_tgt = oldest_idx;
    if (match_found)     on_tgt = match_idx;
    else if (free_found) on_tgt = free_idx;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    on_hit = 1'b1;
`else
    on_hit = match_found | free_found;
`endif
  end

  assign touch     = (state == COMMIT) && (cap.on == NOTE_ON) && on_hit;
  assign scan_load = (state == SEARCH) && ((scan_idx == '0) || scan_older);

  voice_age_tracker #(
    .NVOICES  (NVOICES),
    .AGE_BITS (AGE_BITS),
    .IDX_W    (IDX_W)
  ) u_age (
    .clock      (clock),
    .reset      (reset),
    .gate       (voice_gate),
    .touch      (touch),
    .touch_idx  (on_tgt),
    .scan_load  (scan_load),
    .scan_idx   (scan_idx),
    .scan_older (scan_older),
    .oldest_idx (oldest_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cap         <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      voice_freq  <= '0;
      voice_gate  <= '0;
      voice_note  <= '0;
      voice_trig  <= '0;
      dropped     <= 1'b0;
    end else begin
      voice_trig <= '0;
      dropped    <= 1'b0;
      case (state)
        IDLE: begin
          if (ev.ev_valid) begin
            cap         <= '{on: ev.ev_on, note: ev.ev_note, freq: ev.ev_freq};
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            state       <= SEARCH;
          end
        end
        SEARCH: begin
          // Keep the first hit of each kind so ties resolve to the lowest index.
          if (!match_found && voice_gate[scan_idx] && voice_note[scan_idx] == cap.note) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!free_found && !voice_gate[scan_idx]) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (scan_idx == LAST_IDX) state <= COMMIT;
          else                      scan_idx <= scan_idx + 1'b1;
        end
        COMMIT: begin
          state <= IDLE;
          if (cap.on == NOTE_ON) begin
            if (on_hit) begin
              voice_gate[on_tgt] <= 1'b1;
              voice_note[on_tgt] <= cap.note;
              voice_freq[on_tgt] <= cap.freq;
              voice_trig[on_tgt] <= 1'b1;
            end else begin
              dropped <= 1'b1;
            end
          end else if (match_found) begin
            // Frequency and note stay put so the release tail keeps its pitch.
            voice_gate[match_idx] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
